// File: rtl/dlsc_axi_reader_dw.sv
// dlsc_axi_reader_dw: width-generic AXI read DMA engine that splits byte-addressed commands into aligned bursts
//
// Optional feature macro: DLSC_AXI_READER_DW_ERRSKIP_EN
//   undefined: an error response halts AR issue and drops the erroring beat and all later beats
//   defined:   error beats are forwarded with out_strb=0 and AR issue continues
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   axi_halt                   blocks new AR issue
//   axi_busy                   bursts outstanding on the read port
//   axi_error                  sticky flag, set by any non-OKAY read response
//   cmd_valid/ready/addr/bytes command input: start byte address, byte count minus 1
//   cmd_done                   one-cycle pulse once the final beat of a command is accepted
//   axi_ar_*                   AXI read address channel (beat-aligned address, len = beats-1)
//   axi_r_*                    AXI read data channel
//   out_free                   free entries in the downstream FIFO
//   out_valid/ready/last/data/strb  output stream, out_last marks the last beat of a command
module dlsc_axi_reader_dw #(
    parameter int DATA      = 64,
    parameter int ADDR      = 32,
    parameter int LEN       = 4,
    parameter int BLEN      = 16,
    parameter int MOT       = 16,
    parameter int FIFO_ADDR = 8,
    parameter int STROBE_EN = 1,
    localparam int SB       = DATA/8,
    localparam int LSB      = $clog2(SB)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 axi_halt,
    output logic                 axi_busy,
    output logic                 axi_error,
    output logic                 cmd_done,
    output logic                 cmd_ready,
    input  logic                 cmd_valid,
    input  logic [ADDR-1:0]      cmd_addr,
    input  logic [BLEN-1:0]      cmd_bytes,
    input  logic                 axi_ar_ready,
    output logic                 axi_ar_valid,
    output logic [ADDR-1:0]      axi_ar_addr,
    output logic [LEN-1:0]       axi_ar_len,
    output logic                 axi_r_ready,
    input  logic                 axi_r_valid,
    input  logic                 axi_r_last,
    input  logic [DATA-1:0]      axi_r_data,
    input  logic [1:0]           axi_r_resp,
    input  logic [FIFO_ADDR:0]   out_free,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [DATA-1:0]      out_data,
    output logic [SB-1:0]        out_strb
);

    localparam int BB = LEN + LSB;
    localparam int MA = $clog2(MOT);
    localparam int QW = 1 + 2*LSB;
    localparam int OW = FIFO_ADDR + 2;

    typedef enum logic [0:0] {IDLE, SPLIT} state_t;
    state_t state, state_n;

    logic [ADDR-1:0]    cur, end_addr, boundary, hi;
    logic [LEN:0]       w;
    logic               last_burst, issue, blocked;
    logic               r_acc, r_fwd, r_first, out_acc;
    logic [FIFO_ADDR:0] outstanding;
    logic [QW-1:0]      q_mem [MOT];
    logic [MA-1:0]      q_wr, q_rd;
    logic [MA:0]        q_cnt;
    logic               q_full, q_push, q_pop;
    logic               head_last;
    logic [LSB-1:0]     head_start, head_end;
    logic [SB-1:0]      strb_n;

    // current burst ends at the command end or the last byte of the current full-burst window
    assign boundary   = {cur[ADDR-1:BB], {BB{1'b1}}};
    assign last_burst = end_addr <= boundary;
    assign hi         = last_burst ? end_addr : boundary;
    assign w          = {1'b0, hi[BB-1:LSB]} - {1'b0, cur[BB-1:LSB]} + (LEN+1)'(1);

`ifdef DLSC_AXI_READER_DW_ERRSKIP_EN
    assign blocked     = 1'b0;
    assign axi_r_ready = out_ready || !out_valid;
    assign r_fwd       = r_acc;
`else
    // after an error, R is drained unconditionally and nothing more reaches the output
    assign blocked     = axi_error;
    assign axi_r_ready = out_ready || !out_valid || axi_error;
    assign r_fwd       = r_acc && !axi_error && axi_r_resp == 2'b00;
`endif

    // comparing out_free against outstanding+w avoids underflow when out_free<outstanding
    assign issue = state == SPLIT && !axi_ar_valid && !axi_halt && !blocked && !q_full &&
                   ({1'b0, out_free} >= {1'b0, outstanding} + OW'(w));

    assign cmd_ready = state == IDLE;
    assign q_full    = q_cnt == (MA+1)'(MOT);
    assign axi_busy  = q_cnt != '0;
    assign q_push    = issue;
    assign r_acc     = axi_r_valid && axi_r_ready;
    assign q_pop     = r_acc && axi_r_last;
    assign out_acc   = out_valid && out_ready;
    assign {head_last, head_start, head_end} = q_mem[q_rd];

    always_comb begin
        state_n = (state == IDLE && cmd_valid) ? SPLIT :
                  (state == SPLIT && issue && last_burst) ? IDLE : state;
    end

    // non-first bursts start aligned and non-last bursts end aligned, so per-burst offsets suffice
    always_comb begin
        strb_n = '1;
        for (int i = 0; i < SB; i++) begin
            if (r_first && LSB'(i) < head_start) strb_n[i] = 1'b0;
            if (axi_r_last && LSB'(i) > head_end) strb_n[i] = 1'b0;
        end
        if (STROBE_EN == 0) strb_n = '1;
`ifdef DLSC_AXI_READER_DW_ERRSKIP_EN
        if (axi_r_resp != 2'b00) strb_n = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur          <= '0;
            end_addr     <= '0;
            axi_ar_valid <= 1'b0;
            axi_ar_addr  <= '0;
            axi_ar_len   <= '0;
            outstanding  <= '0;
            q_wr         <= '0;
            q_rd         <= '0;
            q_cnt        <= '0;
            r_first      <= 1'b1;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
            out_strb     <= '1;
            cmd_done     <= 1'b0;
            axi_error    <= 1'b0;
        end else begin
            state <= state_n;
            if (cmd_ready && cmd_valid) begin
                cur      <= cmd_addr;
                end_addr <= cmd_addr + ADDR'(cmd_bytes);
            end else if (issue) begin
                cur <= boundary + ADDR'(1);
            end
            if (issue) begin
                axi_ar_valid <= 1'b1;
                axi_ar_addr  <= {cur[ADDR-1:LSB], {LSB{1'b0}}};
                axi_ar_len   <= LEN'(w - (LEN+1)'(1));
            end else if (axi_ar_ready) begin
                axi_ar_valid <= 1'b0;
            end
            outstanding <= outstanding + (issue ? (FIFO_ADDR+1)'(w) : '0) - (FIFO_ADDR+1)'(out_acc);
            q_wr  <= q_wr + MA'(q_push);
            q_rd  <= q_rd + MA'(q_pop);
            q_cnt <= q_cnt + (MA+1)'(q_push) - (MA+1)'(q_pop);
            if (r_acc) r_first <= axi_r_last;
            if (r_fwd) begin
                out_valid <= 1'b1;
                out_data  <= axi_r_data;
                out_strb  <= strb_n;
                out_last  <= axi_r_last && head_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            cmd_done <= q_pop && head_last;
            if (r_acc && axi_r_resp != 2'b00) axi_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) q_mem[q_wr] <= {last_burst, cur[LSB-1:0], hi[LSB-1:0]};
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && out_free < outstanding) $warning("dlsc_axi_reader_dw: out_free below outstanding");
    end
`endif

endmodule
